// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF synchroniser, prescaler, 3-sample majority per bit,
// framing/overrun detection and a valid/ready holding register. Parity under UART_RX_PARITY_EN.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 1,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 in_bit,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int M   = OVERSAMPLE / 2;
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [OSW-1:0] OS_S0   = OSW'(M - 1);
    localparam logic [OSW-1:0] OS_S1   = OSW'(M);
    localparam logic [OSW-1:0] OS_DEC  = OSW'(M + 1);
    localparam logic [OSW-1:0] OS_END  = OSW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);
    localparam logic [PW-1:0]  PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic                 sync1_q, sync2_q, s;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 tick;
    logic [2:0]           state_q, state_d;
    logic [OSW-1:0]       os_q, os_d;
    logic [BCW-1:0]       bc_q, bc_d;
    logic                 stop_q, stop_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 fpend_q, fpend_d;
    logic                 armed_q, armed_d;
    logic                 par_q, par_d;
    logic                 maj, commit, commit_ferr, commit_perr;

    assign s    = sync2_q;
    assign tick = (presc_q == PRE_LAST);
    // Third sample is the live one; the first two were captured at M-1 and M.
    assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & s) | (smp_q[1] & s);

    always_comb begin
        presc_d     = tick ? '0 : presc_q + 1'b1;
        state_d     = state_q;
        os_d        = os_q;
        bc_d        = bc_q;
        stop_d      = stop_q;
        smp_d       = smp_q;
        shift_d     = shift_q;
        fpend_d     = fpend_q;
        armed_d     = armed_q;
        par_d       = par_q;
        commit      = 1'b0;
        commit_ferr = fpend_q | ~maj;
`ifdef UART_RX_PARITY_EN
        commit_perr = ((^shift_q) ^ 1'(PARITY_ODD)) != par_q;
`else
        commit_perr = 1'b0;
`endif
        if (tick) begin
            if (state_q != S_IDLE) os_d = (os_q == OS_END) ? '0 : os_q + 1'b1;
            if (os_q == OS_S0) smp_d[0] = s;
            if (os_q == OS_S1) smp_d[1] = s;
            case (state_q)
                S_IDLE: begin
                    if (s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = S_START;
                        os_d    = '0;
                        fpend_d = 1'b0;
                    end
                end
                S_START: begin
                    if (os_q == OS_DEC && maj) begin
                        state_d = S_IDLE;
                    end else if (os_q == OS_END) begin
                        state_d = S_DATA;
                        bc_d    = '0;
                    end
                end
                S_DATA: begin
                    if (os_q == OS_DEC) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (os_q == OS_END) begin
                        if (bc_q == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                            stop_d = 1'b0;
                        end else begin
                            bc_d = bc_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (os_q == OS_DEC) par_d = maj;
                    if (os_q == OS_END) state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    if (os_q == OS_DEC) begin
                        if (!maj) fpend_d = 1'b1;
                        // Final stop commits mid-bit; a bad frame disarms so a held break is not re-received.
                        if (stop_q == STOP_LAST) begin
                            commit  = 1'b1;
                            state_d = S_IDLE;
                            if (commit_ferr) armed_d = 1'b0;
                        end
                    end else if (os_q == OS_END) begin
                        stop_d = stop_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            presc_q <= '0;
            state_q <= S_IDLE;
            os_q    <= '0;
            bc_q    <= '0;
            stop_q  <= 1'b0;
            smp_q   <= '0;
            shift_q <= '0;
            fpend_q <= 1'b0;
            armed_q <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            sync1_q <= in_bit;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
            state_q <= state_d;
            os_q    <= os_d;
            bc_q    <= bc_d;
            stop_q  <= stop_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            fpend_q <= fpend_d;
            armed_q <= armed_d;
            par_q   <= par_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (commit) begin
                if (!o_valid || i_ready) begin
                    o_data      <= shift_q;
                    o_frame_err <= commit_ferr;
                    o_valid     <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            o_parity_err <= 1'b0;
        end else if (commit && (!o_valid || i_ready)) begin
            o_parity_err <= commit_perr;
        end
    end
`else
    logic unused_parity;
    assign unused_parity = commit_perr | par_q | (PARITY_ODD != 0);
    assign o_parity_err  = 1'b0;
`endif

    assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os at CLK_DIV=4, OVERSAMPLE=16, 8N1 (parity case under UART_RX_PARITY_EN).
module tb_uart_rx_os;

    localparam int DB      = 8;
    localparam int OS      = 16;
    localparam int CD      = 4;
    localparam int SB      = 1;
    localparam int BIT_CLK = CD * OS;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN  = 1'b1;
`else
    localparam bit PAR_EN  = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          in_bit = 1'b1;
    logic          i_ready = 1'b1;
    logic [DB-1:0] o_data;
    logic          o_valid, o_frame_err, o_parity_err, o_overrun, o_busy;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    logic [DB+1:0] exp_q[$];   // {parity_err, frame_err, data}

    uart_rx_os #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .CLK_DIV   (CD),
        .STOP_BITS (SB),
        .PARITY_ODD(0)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_bit      (in_bit),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_parity_err(o_parity_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        logic [DB+1:0] e;
        if (RST_N && o_overrun === 1'b1) ovr_cnt++;
        if (RST_N && o_valid === 1'b1 && i_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got data=%h ferr=%b perr=%b want none", o_data, o_frame_err, o_parity_err);
            end else begin
                e = exp_q.pop_front();
                checks += 2;
                if (o_data !== e[DB-1:0]) begin
                    errors++;
                    $display("FAIL sb_data got %h want %h", o_data, e[DB-1:0]);
                end
                if (o_frame_err !== e[DB]) begin
                    errors++;
                    $display("FAIL sb_frame_err got %b want %b (data %h)", o_frame_err, e[DB], e[DB-1:0]);
                end
                if (o_parity_err !== e[DB+1]) begin
                    errors++;
                    $display("FAIL sb_parity_err got %b want %b (data %h)", o_parity_err, e[DB+1], e[DB-1:0]);
                end
            end
        end
    end

    task automatic hold(input logic b, input int clks);
        in_bit = b;
        repeat (clks) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // glitch_bit >= 0 inverts one oversample tick at mid-bit of that data bit.
    task automatic send_frame(input logic [DB-1:0] d, input logic par_flip, input logic stop_v,
                              input int idle_bits, input bit push, input int glitch_bit);
        logic par;
        par = (^d) ^ par_flip;
        if (push) exp_q.push_back({par_flip & PAR_EN, ~stop_v, d});
        hold(1'b0, BIT_CLK);
        for (int i = 0; i < DB; i++) begin
            if (i == glitch_bit) begin
                hold(d[i], 32);
                hold(~d[i], CD);
                hold(d[i], BIT_CLK - 32 - CD);
            end else begin
                hold(d[i], BIT_CLK);
            end
        end
        if (PAR_EN) hold(par, BIT_CLK);
        for (int i = 0; i < SB; i++) hold(stop_v, BIT_CLK);
        if (idle_bits > 0) hold(1'b1, idle_bits * BIT_CLK);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending bytes want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        hold(1'b1, 5);
        checks += 6;
        if (o_data !== '0)         begin errors++; $display("FAIL reset_data got %h want 00", o_data); end
        if (o_valid !== 1'b0)      begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        if (o_frame_err !== 1'b0)  begin errors++; $display("FAIL reset_ferr got %b want 0", o_frame_err); end
        if (o_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", o_parity_err); end
        if (o_overrun !== 1'b0)    begin errors++; $display("FAIL reset_ovr got %b want 0", o_overrun); end
        if (o_busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        RST_N = 1'b1;
        hold(1'b1, 2 * BIT_CLK);
    endtask

    task automatic test_basic();
        i_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 2, 1'b1, -1);
        wait_drain("basic", 4 * BIT_CLK);
        checks += 2;
        if (o_busy !== 1'b0)  begin errors++; $display("FAIL basic_busy got %b want 0", o_busy); end
        if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid got %b want 0", o_valid); end
    endtask

    task automatic test_false_start();
        hold(1'b0, 3 * CD);
        hold(1'b1, 3 * BIT_CLK);
        checks += 2;
        if (o_busy !== 1'b0)  begin errors++; $display("FAIL glitch_busy got %b want 0", o_busy); end
        if (o_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b want 0", o_valid); end
        send_frame(8'h3C, 1'b0, 1'b1, 2, 1'b1, -1);
        wait_drain("glitch", 4 * BIT_CLK);
    endtask

    task automatic test_majority();
        send_frame(8'h00, 1'b0, 1'b1, 2, 1'b1, 2);
        wait_drain("majority", 4 * BIT_CLK);
    endtask

    task automatic test_break();
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b1, -1);
        hold(1'b0, 20 * BIT_CLK);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b want 0", o_busy); end
        wait_drain("break", 4 * BIT_CLK);
        hold(1'b1, 2 * BIT_CLK);
        send_frame(8'h5A, 1'b0, 1'b1, 2, 1'b1, -1);
        wait_drain("after_break", 4 * BIT_CLK);
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b0;
        ovr_cnt = 0;
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b1, -1);
        send_frame(8'h22, 1'b0, 1'b1, 2, 1'b0, -1);
        checks += 3;
        if (o_valid !== 1'b1)   begin errors++; $display("FAIL ovr_valid got %b want 1", o_valid); end
        if (o_data !== 8'h11)   begin errors++; $display("FAIL ovr_data got %h want 11", o_data); end
        if (ovr_cnt != 1)       begin errors++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt); end
        i_ready = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got %b want 0", o_valid); end
        wait_drain("back_to_back", 4 * BIT_CLK);
    endtask

    task automatic test_parity();
        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b1, 2, 1'b1, -1);
            send_frame(8'h07, 1'b0, 1'b1, 2, 1'b1, -1);
            wait_drain("parity", 4 * BIT_CLK);
        end
    endtask

    task automatic test_reset_mid_frame();
        hold(1'b0, BIT_CLK);
        hold(1'b1, BIT_CLK);
        hold(1'b0, BIT_CLK + BIT_CLK / 2);
        #2;
        RST_N = 1'b0;
        #1;
        checks += 4;
        if (o_data !== '0)        begin errors++; $display("FAIL midrst_data got %h want 00", o_data); end
        if (o_valid !== 1'b0)     begin errors++; $display("FAIL midrst_valid got %b want 0", o_valid); end
        if (o_busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b want 0", o_busy); end
        if (o_frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr got %b want 0", o_frame_err); end
        hold(1'b1, 4);
        RST_N = 1'b1;
        hold(1'b1, 2 * BIT_CLK);
        send_frame(8'hC3, 1'b0, 1'b1, 2, 1'b1, -1);
        wait_drain("after_reset", 4 * BIT_CLK);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_majority();
        test_break();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
